// File: rtl/fired_tag_fifo.sv
// Show-ahead FIFO of fired-neuron tags between the neuron update stage and
// synaptic_processing_unit; one entry per neuron, cleared at each timestep boundary.
module fired_tag_fifo #(
  parameter int unsigned numneurons = 2,
  parameter int unsigned tagbits    = 1,
  parameter int unsigned cntbits    = 2
) (
  input  logic               clk,
  input  logic               syn_reset_n,
  input  logic               flush,
  input  logic               req_enq,
  input  logic [tagbits-1:0] tag_in,
  input  logic               req_deq,
  output logic [tagbits-1:0] src_tag_out,
  output logic               fifo_empty,
  output logic               fifo_full,
  output logic [cntbits-1:0] fifo_count,
  output logic               overflow,
  output logic               underflow
);

  localparam logic [tagbits-1:0] LAST_PTR  = tagbits'(numneurons - 1);
  localparam logic [cntbits-1:0] CAPACITY  = cntbits'(numneurons);

  logic [tagbits-1:0] mem [numneurons];
  logic [tagbits-1:0] rd_ptr;
  logic [tagbits-1:0] wr_ptr;
  logic [cntbits-1:0] count;

  logic not_empty;
  logic pop_ok;
  logic push_ok;
  logic [tagbits-1:0] rd_ptr_nxt;
  logic [tagbits-1:0] wr_ptr_nxt;

  always_comb begin
    not_empty  = (count != '0);
    pop_ok     = req_deq && not_empty;
    // A full FIFO still accepts a push when the same cycle frees the head slot.
    push_ok    = req_enq && ((count < CAPACITY) || pop_ok);
    rd_ptr_nxt = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
    wr_ptr_nxt = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!syn_reset_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr_nxt;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr_nxt;
      end
      if (push_ok && !pop_ok) begin
        count <= count + 1'b1;
      end else if (pop_ok && !push_ok) begin
        count <= count - 1'b1;
      end
      if (req_enq && !push_ok) begin
        overflow <= 1'b1;
      end
      if (req_deq && !pop_ok) begin
        underflow <= 1'b1;
      end
    end
  end

  // Storage carries no reset; stale entries are masked by count.
  always_ff @(posedge clk) begin
    if (syn_reset_n && !flush && push_ok) begin
      mem[wr_ptr] <= tag_in;
    end
  end

  always_comb begin
    src_tag_out = not_empty ? mem[rd_ptr] : '0;
    fifo_empty  = !not_empty;
    fifo_full   = (count == CAPACITY);
    fifo_count  = count;
  end

endmodule

// File: tb/tb_fired_tag_fifo.sv
// Directed bench for fired_tag_fifo: expected pop tags are queued by stimulus
// and checked by an independent monitor; flags/count are checked directly.
module tb_fired_tag_fifo;

  logic       clk = 1'b0;
  logic       syn_reset_n;
  logic       flush;
  logic       req_enq;
  logic [1:0] tag_in;
  logic       req_deq;
  logic [1:0] src_tag_out;
  logic       fifo_empty;
  logic       fifo_full;
  logic [2:0] fifo_count;
  logic       overflow;
  logic       underflow;

  int n_cmp = 0;
  int n_bad = 0;
  logic [1:0] exp_q [$];

  always #5 clk = ~clk;

  fired_tag_fifo #(
    .numneurons(4),
    .tagbits   (2),
    .cntbits   (3)
  ) dut (
    .clk        (clk),
    .syn_reset_n(syn_reset_n),
    .flush      (flush),
    .req_enq    (req_enq),
    .tag_in     (tag_in),
    .req_deq    (req_deq),
    .src_tag_out(src_tag_out),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_enq = 1'b0;
    req_deq = 1'b0;
    flush   = 1'b0;
  endtask

  // Monitor: a valid consumer handshake is req_deq with a non-empty head.
  always @(negedge clk) begin
    if (syn_reset_n === 1'b1 && flush === 1'b0 && req_deq === 1'b1 && fifo_empty === 1'b0) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL pop_tag: got %0d, expected no pop", src_tag_out);
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        if (src_tag_out !== e) begin
          n_bad++;
          $display("FAIL pop_tag: got %0d, expected %0d", src_tag_out, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    syn_reset_n = 1'b0;
    tag_in = '0;
    idle();
    step();
    step();
    syn_reset_n = 1'b1;
    step();
    chk("rst_empty", fifo_empty, 1);
    chk("rst_count", fifo_count, 0);
    chk("rst_tag", src_tag_out, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);

    // Order: push 2,0,3 then pop three
    req_enq = 1'b1;
    tag_in = 2'd2; exp_q.push_back(2'd2); step(); chk("ord_cnt1", fifo_count, 1);
    tag_in = 2'd0; exp_q.push_back(2'd0); step(); chk("ord_cnt2", fifo_count, 2);
    tag_in = 2'd3; exp_q.push_back(2'd3); step(); chk("ord_cnt3", fifo_count, 3);
    req_enq = 1'b0;
    req_deq = 1'b1;
    step(); chk("ord_cnt_p1", fifo_count, 2);
    step(); chk("ord_cnt_p2", fifo_count, 1);
    step(); chk("ord_cnt_p3", fifo_count, 0);
    idle();
    chk("ord_empty", fifo_empty, 1);

    // Full / overflow: push 1,2,3,0 then a dropped 2
    req_enq = 1'b1;
    tag_in = 2'd1; exp_q.push_back(2'd1); step();
    tag_in = 2'd2; exp_q.push_back(2'd2); step();
    tag_in = 2'd3; exp_q.push_back(2'd3); step();
    tag_in = 2'd0; exp_q.push_back(2'd0); step();
    chk("full_flag", fifo_full, 1);
    chk("full_ovf_pre", overflow, 0);
    tag_in = 2'd2; step();
    idle();
    chk("ovf_full", fifo_full, 1);
    chk("ovf_count", fifo_count, 4);
    chk("ovf_flag", overflow, 1);
    req_deq = 1'b1;
    for (int i = 0; i < 4; i++) step();
    idle();
    chk("ovf_drain_empty", fifo_empty, 1);

    // Full with simultaneous push+pop
    req_enq = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tag_in = 2'(i);
      exp_q.push_back(2'(i));
      step();
    end
    tag_in = 2'd3;
    req_deq = 1'b1;
    exp_q.push_back(2'd3);
    step();
    req_enq = 1'b0;
    chk("simul_count", fifo_count, 4);
    chk("simul_full", fifo_full, 1);
    for (int i = 0; i < 4; i++) step();
    idle();
    chk("simul_empty", fifo_empty, 1);

    // Wrap-around: 10 push/pop pairs
    for (int i = 0; i < 10; i++) begin
      req_enq = 1'b1;
      tag_in = 2'(i % 4);
      exp_q.push_back(2'(i % 4));
      step();
      req_enq = 1'b0;
      req_deq = 1'b1;
      step();
      req_deq = 1'b0;
    end
    chk("wrap_count", fifo_count, 0);
    chk("wrap_unf", underflow, 0);

    // Empty edge cases
    req_deq = 1'b1;
    step();
    req_deq = 1'b0;
    chk("bad_pop_unf", underflow, 1);
    chk("bad_pop_count", fifo_count, 0);
    req_enq = 1'b1;
    req_deq = 1'b1;
    tag_in = 2'd1;
    step();
    idle();
    chk("ep_count", fifo_count, 1);
    chk("ep_head", src_tag_out, 1);
    exp_q.push_back(2'd1);
    req_deq = 1'b1;
    step();
    idle();
    chk("ep_drain", fifo_count, 0);

    // Flush with 3 entries, with a competing push in the flush cycle
    req_enq = 1'b1;
    tag_in = 2'd0; step();
    tag_in = 2'd1; step();
    tag_in = 2'd2; step();
    chk("fl_pre_count", fifo_count, 3);
    flush = 1'b1;
    tag_in = 2'd3;
    step();
    idle();
    chk("fl_count", fifo_count, 0);
    chk("fl_empty", fifo_empty, 1);
    chk("fl_tag", src_tag_out, 0);
    chk("fl_unf", underflow, 1);
    chk("fl_ovf", overflow, 1);

    // Reset mid-burst
    req_enq = 1'b1;
    tag_in = 2'd3; step();
    tag_in = 2'd2; step();
    syn_reset_n = 1'b0;
    tag_in = 2'd1;
    step();
    idle();
    syn_reset_n = 1'b1;
    chk("mr_count", fifo_count, 0);
    chk("mr_empty", fifo_empty, 1);
    chk("mr_tag", src_tag_out, 0);
    chk("mr_unf", underflow, 0);
    chk("mr_ovf", overflow, 0);

    // Post-reset sanity
    req_enq = 1'b1;
    tag_in = 2'd2;
    exp_q.push_back(2'd2);
    step();
    idle();
    chk("pr_head", src_tag_out, 2);
    req_deq = 1'b1;
    step();
    idle();
    chk("pr_empty", fifo_empty, 1);

    step();
    chk("scoreboard_left", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
